sub_32_serial: RTL and testbench

- Multi-cycle 32-bit unsigned subtractor; the inverse operation of the team's 32-bit ripple adder.
- Computes diff = a - b, DIGIT_W bits per clock, LSB digit first, and produces a final borrow.
- Valid/ready handshake on input and output, so the datapath can share a narrow subtract slice instead of a full 32-bit chain.
- Sits beside the adder in the arithmetic lab datapath.

---
 rtl/sub_32_serial_pkg.sv | 19 +
 rtl/sub_32_serial_digit.sv | 22 ++
 rtl/sub_32_serial.sv | 142 ++++++++++++++
 tb/tb_sub_32_serial.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sub_32_serial_pkg.sv
// Shared definitions for the serial subtractor: default sizes, FSM state
// type and the digit-count helper.
package sub32_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int DIGIT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit steps needed to cover an operand of the given width.
    function automatic int num_dig(input int width, input int digit_w);
        return width / digit_w;
    endfunction

endpackage

// File: rtl/sub_32_serial_digit.sv
// sub_digit: combinational DIGIT_W-bit subtract slice with borrow in/out.
// d = x - y - bin (mod 2^DIGIT_W); bout = 1 when the true result is negative.
module sub_digit
    import sub32_pkg::*;
#(
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    logic [DIGIT_W:0] w_full;

    // One extra bit catches the borrow: a negative result sets the top bit.
    assign w_full = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bin};
    assign d      = w_full[DIGIT_W-1:0];
    assign bout   = w_full[DIGIT_W];

endmodule

// File: rtl/sub_32_serial.sv
// sub_32_serial: multi-cycle unsigned subtractor, p = {borrow, a - b},
// computed DIGIT_W bits per clock, least significant digit first.
// Optional signed-overflow output is built when SUB32_OVF_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits on ready, and the producer holds its data
// until the transfer edge. in_ready is high only in IDLE; out_valid is high
// only in DONE, where p (and ovf) are frozen until the output transfer.
module sub_32_serial
    import sub32_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   p,
`ifdef SUB32_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int NUM_DIG = num_dig(WIDTH, DIGIT_W);
    localparam int CNT_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NUM_DIG - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH:0]     r_p;
    logic               r_in_ready;
    logic               r_out_valid;
`ifdef SUB32_OVF_EN
    logic               r_ovf;
`endif

    logic [31:0]        w_base;
    logic [DIGIT_W-1:0] w_x;
    logic [DIGIT_W-1:0] w_y;
    logic [DIGIT_W-1:0] w_d;
    logic               w_bout;
    logic [WIDTH-1:0]   w_diff_next;

    assign w_base = 32'(r_cnt) * 32'(DIGIT_W);

    // Select the current digit of each operand and merge the slice result
    // into a copy of the partial difference.
    always_comb begin
        w_x         = r_a[w_base +: DIGIT_W];
        w_y         = r_b[w_base +: DIGIT_W];
        w_diff_next = r_diff;
        w_diff_next[w_base +: DIGIT_W] = w_d;
    end

    sub_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_sub_digit (
        .x    (w_x),
        .y    (w_y),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // Control FSM plus all datapath registers; p is only loaded once the
    // final digit is known so a partial result never appears on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_p         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef SUB32_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_borrow   <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_bout;
                    if (r_cnt == LAST_DIG) begin
                        r_p         <= {w_bout, w_diff_next};
`ifdef SUB32_OVF_EN
                        r_ovf       <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                       (w_diff_next[WIDTH-1] != r_a[WIDTH-1]);
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign p         = r_p;
`ifdef SUB32_OVF_EN
    assign ovf       = r_ovf;
`endif
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sub_32_serial.sv
// Self-checking bench for sub_32_serial: directed corner operands plus
// random operands, random output backpressure, ignored-input checks and a
// mid-run reset. Expected results come from plain 33-bit / 64-bit arithmetic.
module tb_sub_32_serial;
    import sub32_pkg::*;

    localparam int W     = 32;
    localparam int N_DIG = W / 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W:0]   p;
    logic [1:0]   dbg_state;
`ifdef SUB32_OVF_EN
    logic         ovf;
`endif

    logic [W+1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    sub_32_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
`ifdef SUB32_OVF_EN
        .ovf       (ovf),
`endif
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: {signed overflow, borrow, diff}
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] d;
        longint     sd;
        logic       v;
        d  = {1'b0, x} - {1'b0, y};
        sd = longint'($signed(x)) - longint'($signed(y));
        v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {v, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check latency and result, apply `hold` cycles of
    // backpressure with junk input, then complete the output handshake
    // while offering another input that must not be taken.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
        int cnt;
        logic [W+1:0] e;
        cnt = 0;
        while (!in_ready && cnt < 40) begin
            tick();
            cnt++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
        a = x;
        b = y;
        in_valid = 1'b1;
        exp_q.push_back(model(x, y));
        tick();
        in_valid = 1'b0;
        check("run_state", 64'(dbg_state), 64'(RUN));
        check("busy_in_ready", 64'(in_ready), 64'd0);
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            in_valid = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            tick();
            cnt++;
        end
        in_valid = 1'b0;
        check("latency", 64'(cnt), 64'(N_DIG));
        e = exp_q.pop_front();
        check("diff", 64'(p[W-1:0]), 64'(e[W-1:0]));
        check("borrow", 64'(p[W]), 64'(e[W]));
`ifdef SUB32_OVF_EN
        check("ovf", 64'(ovf), 64'(e[W+1]));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            tick();
            check("hold_p", 64'(p), 64'(e[W:0]));
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = $urandom;
        b = $urandom;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("post_out_valid", 64'(out_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
        check("post_p", 64'(p), 64'(e[W:0]));
    endtask

    initial begin
        logic [W-1:0] ra;
        // Reset
        repeat (3) tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_p", 64'(p), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
`ifdef SUB32_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Directed corners
        run_op(32'd5, 32'd3, 0);
        run_op(32'd3, 32'd5, 1);
        run_op(32'd0, 32'd1, 0);
        run_op(32'd10, 32'd4, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'h8000_0000, 32'd1, 5);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0);

        // Reset during digit 3 of a run
        a = 32'hDEAD_BEEF;
        b = 32'h1234_5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_p", 64'(p), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_state", 64'(dbg_state), 64'(IDLE));
`ifdef SUB32_OVF_EN
        check("abort_ovf", 64'(ovf), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(32'h1234_5678, 32'h0234_5678, 0);

        // Random operands with random backpressure
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0)
                run_op(ra, ra, $urandom_range(0, 3));
            else
                run_op(ra, $urandom, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
